// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared types and constants for the layer sequencer
package nn_seq_pkg;
    localparam int STAGE_W = 8;
    typedef enum logic [3:0] {
        IDLE, INIT, W_INIT, LOAD, W_LOAD, PROC, W_PROC, NEXT, WRITE, W_WRITE, DONE, ERR
    } seq_state_t;
    typedef enum logic [1:0] {NONE, NO_LAYERS, TIMEOUT, ABORT} err_code_t;
endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog: counts cycles spent in one wait phase and flags the limit
module phase_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    logic [15:0] count_q, count_d;
    // reload on phase entry, count while waiting, saturate rather than wrap
    always_comb count_d = clear_i ? '0 : (enable_i && !(&count_q)) ? count_q + 16'd1 : count_q;
    // count register
    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else count_q <= count_d;
    // count_q holds completed cycles, so the current cycle is the last allowed one
    assign expired_o = enable_i && count_q >= 16'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: host-facing control FSM walking the auxiliary FSM through init, layers and write-back
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               registers_initialized,
    input  logic               data_loaded,
    input  logic               data_processed,
    input  logic               output_written,
    input  logic [STAGE_W-1:0] totalLayerNumber,
    output logic               begin_initialize_registers,
    output logic               begin_load_data,
    output logic               begin_process_data,
    output logic               begin_write_output,
    output logic [STAGE_W-1:0] stage,
    output logic               busy,
    output logic               done,
    output logic               irq,
    output logic               error,
    output logic [1:0]         error_code,
    output logic [31:0]        cycle_count
);
    seq_state_t         state_q, state_d;
    err_code_t          err_q, err_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               waiting, busy_st, accept, expired;
    logic               b_init_q, b_load_q, b_proc_q, b_write_q;
    logic               busy_q, done_q, irq_q, error_q;
    logic [31:0]        cycle_count_q;

    assign waiting = state_q inside {W_INIT, W_LOAD, W_PROC, W_WRITE};
    assign busy_st = !(state_q inside {IDLE, DONE, ERR});
    assign accept  = (state_q inside {IDLE, DONE}) && start;

    phase_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q inside {INIT, LOAD, PROC, WRITE}),
        .enable_i (waiting),
        .expired_o(expired)
    );

    // next state: done pulses beat the watchdog, abort beats everything
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        stage_d = stage_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = INIT;
                stage_d = '0;
            end
            INIT:    state_d = W_INIT;
            W_INIT:  if (registers_initialized) begin
                if (totalLayerNumber < STAGE_W'(2)) begin
                    state_d = ERR;
                    err_d   = NO_LAYERS;
                end else begin
                    state_d = LOAD;
                    stage_d = STAGE_W'(1);
                end
            end
            LOAD:    state_d = W_LOAD;
            W_LOAD:  if (data_loaded) state_d = PROC;
            PROC:    state_d = W_PROC;
            W_PROC:  if (data_processed) state_d = NEXT;
            NEXT:    if (stage_q == totalLayerNumber - STAGE_W'(1)) state_d = WRITE;
                     else begin
                         state_d = LOAD;
                         stage_d = stage_q + STAGE_W'(1);
                     end
            WRITE:   state_d = W_WRITE;
            W_WRITE: if (output_written) state_d = DONE;
            default: ;
        endcase
        if (waiting && expired && state_d == state_q) begin
            state_d = ERR;
            err_d   = TIMEOUT;
        end
        if (busy_st && abort) begin
            state_d = ERR;
            err_d   = ABORT;
        end
    end

    // state and registered outputs, all derived from the next state
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q       <= IDLE;
            err_q         <= NONE;
            stage_q       <= '0;
            b_init_q      <= 1'b0;
            b_load_q      <= 1'b0;
            b_proc_q      <= 1'b0;
            b_write_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            irq_q         <= 1'b0;
            error_q       <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            stage_q       <= stage_d;
            b_init_q      <= state_d == INIT;
            b_load_q      <= state_d == LOAD;
            b_proc_q      <= state_d == PROC;
            b_write_q     <= state_d == WRITE;
            busy_q        <= !(state_d inside {IDLE, DONE, ERR});
            done_q        <= state_d == DONE;
            irq_q         <= (state_d inside {DONE, ERR}) && state_d != state_q;
            error_q       <= state_d == ERR;
            cycle_count_q <= accept ? '0 : (busy_q && !(&cycle_count_q)) ? cycle_count_q + 32'd1 : cycle_count_q;
        end

    assign begin_initialize_registers = b_init_q;
    assign begin_load_data            = b_load_q;
    assign begin_process_data         = b_proc_q;
    assign begin_write_output         = b_write_q;
    assign stage                      = stage_q;
    assign busy                       = busy_q;
    assign done                       = done_q;
    assign irq                        = irq_q;
    assign error                      = error_q;
    assign error_code                 = err_q;
    assign cycle_count                = cycle_count_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: directed scoreboard bench with a simple auxiliary FSM model
module tb_nn_layer_sequencer;
    typedef struct {
        int kind;
        int stg;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        m_ri = 1'b0, m_dl = 1'b0, m_dp = 1'b0, m_ow = 1'b0;
    logic        x_dl = 1'b0, x_dp = 1'b0;
    logic        ri, dl, dp, ow;
    logic [7:0]  total = 8'd3;
    logic        b_init, b_load, b_proc, b_write;
    logic [7:0]  stage;
    logic        busy, done, irq, error;
    logic [1:0]  error_code;
    logic [31:0] cycle_count;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cnt = 0;
    int  kind_p = 0;
    int  last_k = 0;
    int  irq_cnt = 0;
    int  base = 0;
    int  nb = 0;
    bit  mute_load = 1'b0;
    logic prev_irq = 1'b0;

    assign ri = m_ri;
    assign dl = m_dl | x_dl;
    assign dp = m_dp | x_dp;
    assign ow = m_ow;

    always #5 clk = ~clk;

    nn_layer_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .abort                     (abort),
        .registers_initialized     (ri),
        .data_loaded               (dl),
        .data_processed            (dp),
        .output_written            (ow),
        .totalLayerNumber          (total),
        .begin_initialize_registers(b_init),
        .begin_load_data           (b_load),
        .begin_process_data        (b_proc),
        .begin_write_output        (b_write),
        .stage                     (stage),
        .busy                      (busy),
        .done                      (done),
        .irq                       (irq),
        .error                     (error),
        .error_code                (error_code),
        .cycle_count               (cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input int s);
        ev_t e;
        e.kind = k;
        e.stg  = s;
        exp_q.push_back(e);
    endtask

    // one cycle: advance the auxiliary model, then score any command issued this cycle
    task automatic tick();
        int  k;
        ev_t e;
        @(negedge clk);
        {m_ri, m_dl, m_dp, m_ow} = 4'b0;
        if (reset) cnt = 0;
        else if (cnt > 0) begin
            cnt--;
            if (cnt == 0)
                case (kind_p)
                    1: m_ri = 1'b1;
                    2: m_dl = !mute_load;
                    3: m_dp = 1'b1;
                    4: m_ow = 1'b1;
                    default: ;
                endcase
        end
        k = b_init ? 1 : b_load ? 2 : b_proc ? 3 : b_write ? 4 : 0;
        last_k = k;
        if (k != 0 && !reset) begin
            cnt    = 4;
            kind_p = k;
            if (exp_q.size() == 0) chk("unexpected_cmd", k, 0);
            else begin
                e = exp_q.pop_front();
                chk("cmd_kind", k, e.kind);
                chk("cmd_stage", stage, e.stg);
            end
        end
        if (irq) begin
            irq_cnt++;
            chk("irq_single_cycle", prev_irq, 0);
        end
        prev_irq = irq;
        if (done || error) chk("done_excl_error", done & error, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        {x_dl, x_dp, abort, start} = 4'b0;
        mute_load = 1'b0;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_on_start", busy, 1);
    endtask

    task automatic wait_cmd(input int k, input int s);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (last_k == k && stage == 8'(s)) break;
        end
        chk("wait_cmd", (last_k == k) ? 32'd1 : 32'd0, 1);
    endtask

    task automatic run_wait(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            if (done || error) break;
            if (busy) n++;
            tick();
        end
        chk("run_ended", done | error, 1);
    endtask

    initial begin
        #1;
        chk("reset_outputs", {b_init, b_load, b_proc, b_write, busy, done, irq, error, error_code, stage}, 0);
        chk("reset_cycle_count", cycle_count, 0);
        tick();
        reset = 1'b0;
        tick();

        // normal three-layer run
        total = 8'd3;
        push(1, 0); push(2, 1); push(3, 1); push(2, 2); push(3, 2); push(4, 2);
        base = irq_cnt;
        do_start();
        run_wait(400, nb);
        chk("run3_done", done, 1);
        chk("run3_error", error, 0);
        chk("run3_busy", busy, 0);
        chk("run3_irq", irq, 1);
        chk("run3_stage_hold", stage, 2);
        chk("run3_cycle_count", cycle_count, nb);
        chk("run3_all_cmds", exp_q.size(), 0);
        tick();
        tick();
        chk("run3_irq_low", irq, 0);
        chk("run3_done_sticky", done, 1);
        chk("run3_irq_count", irq_cnt - base, 1);

        // too few layers
        do_reset();
        total = 8'd1;
        push(1, 0);
        do_start();
        run_wait(100, nb);
        chk("nolayer_error", error, 1);
        chk("nolayer_code", error_code, 1);
        chk("nolayer_done", done, 0);
        chk("nolayer_irq", irq, 1);
        repeat (10) tick();
        chk("nolayer_no_load", exp_q.size(), 0);

        // load timeout
        do_reset();
        total = 8'd3;
        mute_load = 1'b1;
        push(1, 0); push(2, 1);
        do_start();
        wait_cmd(2, 1);
        tick();
        repeat (15) tick();
        chk("to_pre_error", error, 0);
        chk("to_pre_busy", busy, 1);
        tick();
        chk("to_error", error, 1);
        chk("to_code", error_code, 2);
        chk("to_irq", irq, 1);
        chk("to_busy", busy, 0);

        // done pulse on the expiry edge wins
        do_reset();
        mute_load = 1'b1;
        push(1, 0); push(2, 1);
        do_start();
        wait_cmd(2, 1);
        tick();
        repeat (15) tick();
        x_dl = 1'b1;
        mute_load = 1'b0;
        push(3, 1); push(2, 2); push(3, 2); push(4, 2);
        tick();
        x_dl = 1'b0;
        chk("edge_no_error", error, 0);
        chk("edge_proc_issued", b_proc, 1);
        run_wait(400, nb);
        chk("edge_done", done, 1);
        chk("edge_all_cmds", exp_q.size(), 0);

        // abort during processing of layer 2
        do_reset();
        total = 8'd3;
        push(1, 0); push(2, 1); push(3, 1); push(2, 2); push(3, 2);
        base = irq_cnt;
        do_start();
        wait_cmd(3, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_error", error, 1);
        chk("abort_code", error_code, 3);
        chk("abort_irq", irq, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        start = 1'b1;
        repeat (6) tick();
        start = 1'b0;
        chk("abort_start_ignored", busy, 0);
        chk("abort_error_sticky", error, 1);
        chk("abort_irq_count", irq_cnt - base, 1);

        // start held high throughout, plus a stray processed pulse during load
        do_reset();
        total = 8'd2;
        push(1, 0); push(2, 1); push(3, 1); push(4, 1);
        start = 1'b1;
        tick();
        chk("hold_busy", busy, 1);
        wait_cmd(2, 1);
        tick();
        x_dp = 1'b1;
        tick();
        x_dp = 1'b0;
        chk("stray_dp_ignored", b_proc, 0);
        run_wait(400, nb);
        chk("hold_done", done, 1);
        chk("hold_all_cmds", exp_q.size(), 0);
        push(1, 0);
        tick();
        chk("reaccept_done_clr", done, 0);
        chk("reaccept_busy", busy, 1);
        chk("reaccept_cycles", cycle_count, 0);
        chk("reaccept_stage", stage, 0);
        start = 1'b0;
        push(2, 1); push(3, 1); push(4, 1);
        run_wait(400, nb);
        chk("reaccept_run_done", done, 1);
        chk("reaccept_cycle_count", cycle_count, nb);

        // reset in the middle of a load
        do_reset();
        total = 8'd3;
        push(1, 0); push(2, 1);
        do_start();
        wait_cmd(2, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("midreset_outputs", {b_init, b_load, b_proc, b_write, busy, done, irq, error, error_code, stage}, 0);
        chk("midreset_cycles", cycle_count, 0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        push(1, 0); push(2, 1); push(3, 1); push(2, 2); push(3, 2); push(4, 2);
        do_start();
        run_wait(400, nb);
        chk("after_reset_done", done, 1);
        chk("after_reset_stage", stage, 2);
        chk("after_reset_cycles", cycle_count, nb);
        chk("after_reset_cmds", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
